mor1kx_traceport_source: RTL
============================

MOR1KX_TRACEPORT_SOURCE -- requirements
Module: mor1kx_traceport_source

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, meaning writeback data width.
REQ-002 SHALL have parameter OPTION_RF_ADDR_WIDTH, default 5, meaning register index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning retire buffer entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port retire_valid_i  input  1  one instruction retires this cycle.
REQ-007 SHALL have ports retire_pc_i and retire_insn_i  input  32 each  retiring PC and instruction word.
REQ-008 SHALL have ports retire_wben_i (input, 1) and retire_wbreg_i (input, OPTION_RF_ADDR_WIDTH)  register write enable and index.
REQ-009 SHALL have port retire_wbdata_i  input  OPTION_OPERAND_WIDTH  writeback data; valid only when retire_load_i=0.
REQ-010 SHALL have port retire_load_i  input  1  writeback data arrives later via LSU.
REQ-011 SHALL have ports lsu_data_valid_i (input, 1) and lsu_data_i (input, OPTION_OPERAND_WIDTH)  late load data, in program order.
REQ-012 SHALL have outputs traceport_exec_valid (1), _pc (32), _insn (32), _wbdata (OPTION_OPERAND_WIDTH), _wbreg (OPTION_RF_ADDR_WIDTH), _wben (1)  traceport to the monitor.
REQ-013 SHALL have port overflow_o  output  1  sticky flag for dropped retire events.

Function
REQ-014 SHALL write each accepted retire event into an in-order FIFO entry {pc, insn, wben, wbreg, wbdata, complete}; complete=1 unless retire_load_i=1.
REQ-015 SHALL deliver lsu_data_i to the oldest entry with complete=0, storing wbdata and setting complete=1.
REQ-016 SHALL, when lsu_data_valid_i and retire_valid_i with retire_load_i coincide and no pending entry exists in the FIFO, apply the data to the retiring entry (stored complete).
REQ-017 SHALL ignore lsu_data_valid_i when no pending load exists (no state change).
REQ-018 SHALL pop the head entry when complete and drive it on the traceport registers next cycle, at most one per cycle, traceport_exec_valid a one-cycle pulse per entry.
REQ-019 SHALL achieve latency of one cycle: complete event retired at cycle N with empty FIFO shows traceport_exec_valid in cycle N+1; load head completed by LSU at cycle M emits in cycle M+1.
REQ-020 SHALL hold traceport data outputs stable when traceport_exec_valid=0.
REQ-021 SHALL never reorder events; a pending head blocks younger complete entries.
REQ-022 SHALL, when the FIFO is full and no pop occurs that cycle, drop the retiring event and set overflow_o=1 until reset; full with a simultaneous pop SHALL accept.
REQ-023 SHALL handle pointer wrap-around modulo FIFO_DEPTH with a separate occupancy count 0..FIFO_DEPTH.

Reset
REQ-024 SHALL, on rst low, asynchronously clear FIFO pointers/count, overflow_o, traceport_exec_valid, and all traceport data outputs to 0.
REQ-025 SHALL discard in-flight entries and pending loads on reset mid-operation; post-reset LSU data is ignored until a new load retires.

Configuration
REQ-026 SHALL support macro MOR1KX_TRACEPORT_WINDOW_EN; when defined, a trace window (closed at reset) opens on emission of insn 32'h15000064 and closes on 32'h150000c8, and only entries emitted with the window open, plus these two nops and nops 32'h15000001/02/04/0c, SHALL raise traceport_exec_valid.
REQ-027 SHALL, without MOR1KX_TRACEPORT_WINDOW_EN, emit every retired event and contain no window state.

Verification
REQ-028 SHALL cover: retire pc=0x100, insn=0xE0632000, wben=1, wbreg=3, wbdata=0x5 on empty FIFO -> next cycle valid=1 with identical fields, one pulse.
REQ-029 SHALL cover: load retire pc=0x200 wbreg=4, then non-load pc=0x204, LSU data 0xDEADBEEF three cycles later -> 0x200 emitted with 0xDEADBEEF in following cycle, 0x204 the cycle after.
REQ-030 SHALL cover: load retire and lsu_data_valid same cycle, FIFO empty, lsu_data_i=0x1234 -> emitted next cycle with wbdata=0x1234.
REQ-031 SHALL cover: head load pending, five retires (FIFO_DEPTH=4) -> fifth dropped, overflow_o=1 held; after LSU data, four events emit in order.
REQ-032 SHALL cover: rst low while three entries buffered -> outputs 0 immediately, no emission after release; with MOR1KX_TRACEPORT_WINDOW_EN, insn 0x15000064, add, 0x150000c8, add -> only first add plus both nops emitted.

Source files
------------

// File: rtl/mor1kx_traceport_source.sv
// In-order retire buffer feeding the mor1kx traceport; loads wait for late LSU data.
// Optional trace window gating is enabled with `define MOR1KX_TRACEPORT_WINDOW_EN.
module mor1kx_traceport_source #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            retire_valid_i,
  input  logic [31:0]                     retire_pc_i,
  input  logic [31:0]                     retire_insn_i,
  input  logic                            retire_wben_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] retire_wbreg_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] retire_wbdata_i,
  input  logic                            retire_load_i,
  input  logic                            lsu_data_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_data_i,
  output logic                            traceport_exec_valid,
  output logic [31:0]                     traceport_exec_pc,
  output logic [31:0]                     traceport_exec_insn,
  output logic [OPTION_OPERAND_WIDTH-1:0] traceport_exec_wbdata,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] traceport_exec_wbreg,
  output logic                            traceport_exec_wben,
  output logic                            overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]                     ent_pc       [FIFO_DEPTH];
  logic [31:0]                     ent_insn     [FIFO_DEPTH];
  logic                            ent_wben     [FIFO_DEPTH];
  logic [OPTION_RF_ADDR_WIDTH-1:0] ent_wbreg    [FIFO_DEPTH];
  logic [OPTION_OPERAND_WIDTH-1:0] ent_wbdata   [FIFO_DEPTH];
  logic                            ent_complete [FIFO_DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr, pend_idx, scan_idx;
  logic [CW-1:0] count;
  logic          pend_found;
  logic          lsu_fifo, lsu_head, lsu_retire, retire_cmpl;
  logic          pop, bypass, retire_acc, store, vld_p0, vld_vis_p0;
  logic [31:0]                     pc_p0, insn_p0;
  logic                            wben_p0;
  logic [OPTION_RF_ADDR_WIDTH-1:0] wbreg_p0;
  logic [OPTION_OPERAND_WIDTH-1:0] wbdata_p0;

  // Oldest occupied entry still waiting for load data
  always_comb begin
    pend_found = 1'b0;
    pend_idx   = rd_ptr;
    scan_idx   = rd_ptr;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      scan_idx = rd_ptr + AW'(i);
      if (!pend_found && (CW'(i) < count) && !ent_complete[scan_idx]) begin
        pend_found = 1'b1;
        pend_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    lsu_fifo    = lsu_data_valid_i && pend_found;
    lsu_head    = lsu_fifo && (pend_idx == rd_ptr);
    lsu_retire  = lsu_data_valid_i && !pend_found && retire_valid_i && retire_load_i;
    retire_cmpl = !retire_load_i || lsu_retire;
    pop         = (count != '0) && (ent_complete[rd_ptr] || lsu_head);
    // An empty buffer lets a complete retire go straight to the output registers
    bypass      = (count == '0) && retire_valid_i && retire_cmpl;
    retire_acc  = retire_valid_i && ((count < DEPTH_C) || pop);
    store       = retire_acc && !bypass;
    vld_p0      = pop || bypass;
    pc_p0       = bypass ? retire_pc_i    : ent_pc[rd_ptr];
    insn_p0     = bypass ? retire_insn_i  : ent_insn[rd_ptr];
    wben_p0     = bypass ? retire_wben_i  : ent_wben[rd_ptr];
    wbreg_p0    = bypass ? retire_wbreg_i : ent_wbreg[rd_ptr];
    if (bypass)
      wbdata_p0 = lsu_retire ? lsu_data_i : retire_wbdata_i;
    else
      wbdata_p0 = lsu_head ? lsu_data_i : ent_wbdata[rd_ptr];
  end

`ifdef MOR1KX_TRACEPORT_WINDOW_EN
  localparam logic [31:0] NOP_OPEN  = 32'h15000064;
  localparam logic [31:0] NOP_CLOSE = 32'h150000c8;

  function automatic logic is_marker(input logic [31:0] insn);
    return (insn == NOP_OPEN) || (insn == NOP_CLOSE) ||
           (insn == 32'h15000001) || (insn == 32'h15000002) ||
           (insn == 32'h15000004) || (insn == 32'h1500000c);
  endfunction

  logic window_q;

  always_comb vld_vis_p0 = vld_p0 && (window_q || is_marker(insn_p0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      window_q <= 1'b0;
    else if (vld_p0 && (insn_p0 == NOP_OPEN))
      window_q <= 1'b1;
    else if (vld_p0 && (insn_p0 == NOP_CLOSE))
      window_q <= 1'b0;
  end
`else
  always_comb vld_vis_p0 = vld_p0;
`endif

  // Control: pointers, occupancy, sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (store)
        wr_ptr <= wr_ptr + AW'(1);
      if (store && !pop)
        count <= count + CW'(1);
      else if (!store && pop)
        count <= count - CW'(1);
      if (retire_valid_i && !retire_acc)
        overflow_o <= 1'b1;
    end
  end

  // Entry storage; a retire into the slot being popped must override the LSU write
  always_ff @(posedge clk) begin
    if (lsu_fifo) begin
      ent_wbdata[pend_idx]   <= lsu_data_i;
      ent_complete[pend_idx] <= 1'b1;
    end
    if (store) begin
      ent_pc[wr_ptr]       <= retire_pc_i;
      ent_insn[wr_ptr]     <= retire_insn_i;
      ent_wben[wr_ptr]     <= retire_wben_i;
      ent_wbreg[wr_ptr]    <= retire_wbreg_i;
      ent_wbdata[wr_ptr]   <= lsu_retire ? lsu_data_i : retire_wbdata_i;
      ent_complete[wr_ptr] <= retire_cmpl;
    end
  end

  // Output stage: data only moves on a visible emission
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      traceport_exec_valid  <= 1'b0;
      traceport_exec_pc     <= '0;
      traceport_exec_insn   <= '0;
      traceport_exec_wbdata <= '0;
      traceport_exec_wbreg  <= '0;
      traceport_exec_wben   <= 1'b0;
    end else begin
      traceport_exec_valid <= vld_vis_p0;
      if (vld_vis_p0) begin
        traceport_exec_pc     <= pc_p0;
        traceport_exec_insn   <= insn_p0;
        traceport_exec_wbdata <= wbdata_p0;
        traceport_exec_wbreg  <= wbreg_p0;
        traceport_exec_wben   <= wben_p0;
      end
    end
  end

endmodule
